// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pad synchronizers, clock deglitch filter,
// 11-bit frame deframer with timeout, and scan-code set 2 make/break/E0 layer.
`timescale 1ns/1ps

module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_rel,
  output logic       key_valid
);

  localparam int unsigned FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_clk_s1, r_clk_s2;
  logic            r_dat_s1, r_dat_s2;
  logic            r_clk_filt;
  logic [FC_W-1:0] r_filt_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;

  logic [7:0]      r_byte_data;
  logic            r_byte_valid;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_busy;
  logic [7:0]      r_key_code;
  logic            r_key_ext;
  logic            r_key_rel;
  logic            r_key_valid;
  logic            r_ext_flag;
  logic            r_rel_flag;

  logic            w_dat;
  logic            w_filt_done;
  logic            w_strobe;
  logic            w_timeout;
  logic            w_par_ok;
  logic            w_start;
  logic            w_shift;
  logic            w_par_ld;
  logic            w_stop;

  assign w_dat       = r_dat_s2;
  assign w_filt_done = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FC_W'(FILTER_LEN - 1));
  // Strobe coincides with the filtered clock committing to a falling level.
  assign w_strobe    = w_filt_done && !r_clk_s2;
  assign w_timeout   = (r_state != IDLE) && !w_strobe && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign w_par_ok    = ^{r_shift, r_par};

  // Two-flop synchronizers on both pads, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock follows the synchronized clock after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_done) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FC_W'(1);
    end
  end

  // Inter-strobe watchdog; only runs while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_strobe || (r_state == IDLE)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next state and datapath enables.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_par_ld    = 1'b0;
    w_stop      = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_strobe) begin
      case (r_state)
        IDLE: begin
          if (!w_dat) begin
            w_state_nxt = DATA;
            w_start     = 1'b1;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end
        end
        PARITY: begin
          w_par_ld    = 1'b1;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_stop      = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and frame-level result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= (w_state_nxt != IDLE);
      if (w_start) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end
      if (w_shift) begin
        r_shift   <= {w_dat, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_ld) begin
        r_par <= w_dat;
      end
      if (w_timeout) begin
        r_frame_err <= 1'b1;
      end else if (w_stop) begin
        if (!w_dat) begin
          r_frame_err <= 1'b1;
        end else if (!w_par_ok) begin
          r_parity_err <= 1'b1;
        end else begin
          r_byte_data  <= r_shift;
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

  // Scan-code layer: collect E0/F0 prefixes, emit one event per final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_rel   <= 1'b0;
      r_key_valid <= 1'b0;
      r_ext_flag  <= 1'b0;
      r_rel_flag  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_parity_err || r_frame_err) begin
        r_ext_flag <= 1'b0;
        r_rel_flag <= 1'b0;
      end else if (r_byte_valid) begin
        if (r_byte_data == 8'hE0) begin
          r_ext_flag <= 1'b1;
        end else if (r_byte_data == 8'hF0) begin
          r_rel_flag <= 1'b1;
        end else begin
          r_key_code  <= r_byte_data;
          r_key_ext   <= r_ext_flag;
          r_key_rel   <= r_rel_flag;
          r_key_valid <= 1'b1;
          r_ext_flag  <= 1'b0;
          r_rel_flag  <= 1'b0;
        end
      end
    end
  end

  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_rel    = r_key_rel;
  assign key_valid  = r_key_valid;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed frames push expected events,
// a monitor pops and compares whenever the receiver pulses an output.
`timescale 1ns/1ps

module tb_ps2_keyboard_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TO   = 600;

  typedef enum int {EV_BYTE, EV_PERR, EV_FERR, EV_KEY} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] data;
    logic       ext;
    logic       rel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_rel;
  logic       key_valid;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ps2_keyboard_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_rel   (key_rel),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic exp_byte(input logic [7:0] d);
    exp_t e;
    e.kind = EV_BYTE; e.data = d; e.ext = 1'b0; e.rel = 1'b0;
    q.push_back(e);
  endtask

  task automatic exp_key(input logic [7:0] d, input logic ext, input logic rel);
    exp_t e;
    e.kind = EV_KEY; e.data = d; e.ext = ext; e.rel = rel;
    q.push_back(e);
  endtask

  // Error events carry the byte_data value that must still be held.
  task automatic exp_err(input ev_t kind, input logic [7:0] held);
    exp_t e;
    e.kind = kind; e.data = held; e.ext = 1'b0; e.rel = 1'b0;
    q.push_back(e);
  endtask

  task automatic pop_check(input ev_t kind);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got event kind %0d, expected no event", kind);
    end else begin
      e = q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == EV_KEY) begin
        check("key_code", 32'(key_code), 32'(e.data));
        check("key_ext", 32'(key_ext), 32'(e.ext));
        check("key_rel", 32'(key_rel), 32'(e.rel));
      end else begin
        check("byte_data", 32'(byte_data), 32'(e.data));
      end
    end
  endtask

  // Monitor: compare every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    int n;
    if (rst_n) begin
      n = int'(byte_valid) + int'(parity_err) + int'(frame_err);
      if (n > 0) check("one_result_pulse", 32'(n), 32'd1);
      if (byte_valid) pop_check(EV_BYTE);
      if (parity_err) pop_check(EV_PERR);
      if (frame_err)  pop_check(EV_FERR);
      if (key_valid)  pop_check(EV_KEY);
    end
  end

  task automatic ps2_bit(input logic b, input int half);
    @(negedge clk);
    ps2_dat = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame: start, 8 data LSB first, odd parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input int half, input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], half);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (4 * half) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_byte_data", 32'(byte_data), 32'h00);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_key_code", 32'(key_code), 32'h00);
    check("rst_key_ext", 32'(key_ext), 32'd0);
    check("rst_key_rel", 32'(key_rel), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic glitch_busy;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Plain make code 0x1C.
    exp_byte(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 20, 11);
    check("busy_idle_after_frame", 32'(busy), 32'd0);

    // Extended break E0 F0 75 at minimum half-period, then a plain 0x1C.
    exp_byte(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1, FILT + 3, 11);
    exp_byte(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, FILT + 3, 11);
    exp_byte(8'h75); exp_key(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, FILT + 3, 11);
    exp_byte(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 30, 11);

    // Bad parity, then bad stop bit; byte_data must hold 0x1C.
    exp_err(EV_PERR, 8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1, 20, 11);
    exp_err(EV_FERR, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 20, 11);

    // Parity error drops a pending F0 prefix.
    exp_byte(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 20, 11);
    exp_err(EV_PERR, 8'hF0);
    send_frame(8'h29, 1'b1, 1'b1, 20, 11);
    exp_byte(8'h29); exp_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 20, 11);

    // Timeout after start + 5 data bits drops a pending E0 prefix.
    exp_byte(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1, 20, 11);
    exp_err(EV_FERR, 8'hE0);
    for (int i = 0; i < 6; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1, 20);
    repeat (2) @(negedge clk);
    check("busy_mid_frame", 32'(busy), 32'd1);
    repeat (TO + 10) @(negedge clk);
    check("busy_after_timeout", 32'(busy), 32'd0);
    exp_byte(8'h5A); exp_key(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 20, 11);

    // Short low glitches on ps2_clk with data low must not open a frame.
    glitch_busy = 1'b0;
    ps2_dat = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        glitch_busy = glitch_busy | busy;
      end
    end
    ps2_dat = 1'b1;
    check("glitch_busy", 32'(glitch_busy), 32'd0);

    // Reset mid-frame with a pending F0 prefix, then a clean 0x1C.
    exp_byte(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 20, 11);
    send_frame(8'h33, 1'b0, 1'b1, 20, 4);
    check("busy_before_reset", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_byte(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 20, 11);

    repeat (50) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 host-side receiver for the DE2-115 PS2_CLK/PS2_DAT pads: it deframes the 11-bit device-to-host frames a keyboard transmits and assembles scan-code set 2 make/break events, including the E0 extended prefix. It sits between the board pads and GameLogic, so paddles can be driven from a keyboard as well as from KEY[3:0]. It is receive-only and never drives the PS/2 lines; the top level keeps both pads at high impedance.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 25200: idle clk cycles allowed between falling edges inside a frame (about 1 ms at 25.2 MHz).

Ports:
- clk  in  1  system clock (clk_vga domain).
- rst_n  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  raw PS2_CLK pad, asynchronous to clk.
- ps2_dat  in  1  raw PS2_DAT pad, asynchronous to clk.
- byte_data  out  8  last correctly received byte.
- byte_valid  out  1  one-cycle pulse; byte_data is new.
- parity_err  out  1  one-cycle pulse; frame discarded for bad odd parity.
- frame_err  out  1  one-cycle pulse; stop bit was 0, or a timeout occurred.
- busy  out  1  high while a frame is in progress (state other than IDLE).
- key_code  out  8  scan code of the last key event.
- key_ext  out  1  the event was preceded by E0.
- key_rel  out  1  the event was preceded by F0 (break).
- key_valid  out  1  one-cycle pulse; the key_* outputs are new.

## Operation
- Input path: two-flop synchronizer on each pad; both flops reset to 1.
- Clock filter: the filtered clock takes the synchronized ps2_clk value only after FILTER_LEN consecutive equal samples. It resets to 1.
- Sampling: each 1-to-0 transition of the filtered clock is a sample strobe. On a strobe, the synchronized ps2_dat is sampled.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with dat=0 moves to DATA and clears the bit counter. Strobe with dat=1 is ignored (stay IDLE, no error).
  - DATA: shift in 8 bits, LSB first. After the 8th bit, move to PARITY.
  - PARITY: store the parity bit. Move to STOP.
  - STOP: on the strobe, return to IDLE and check, in this priority order:
    - stop bit = 0: frame_err.
    - else parity bad (the 9 bits do not hold an odd number of ones): parity_err.
    - else: byte_data updated, byte_valid.
- Timeout: the counter clears on every strobe and counts while state is not IDLE. On reaching TIMEOUT_CYCLES: return to IDLE and pulse frame_err. The shift register is discarded and byte_data is unchanged.
- Scan-code layer, on each byte_valid:
  - byte 0xE0: set the ext flag.
  - byte 0xF0: set the rel flag.
  - any other byte: key_code = byte, key_ext = ext flag, key_rel = rel flag, pulse key_valid, then clear both flags.
- Any parity_err or frame_err clears both prefix flags.
- At most one of byte_valid, parity_err, frame_err is asserted in any cycle.
- Reset mid-frame: the FSM is forced to IDLE immediately. All flags, counters and outputs clear.

## Timing
- Reset values: byte_data=0x00, byte_valid=0, parity_err=0, frame_err=0, busy=0, key_code=0x00, key_ext=0, key_rel=0, key_valid=0.
- Pad-to-strobe latency: a stable pad fall produces its strobe 2+FILTER_LEN clk cycles later.
- byte_valid, parity_err and frame_err (stop-bit case) are registered. They assert in the cycle after the stop-bit strobe.
- key_valid asserts one cycle after the byte_valid of the final byte.
- key_code, key_ext, key_rel and byte_data hold their values until the next update.
- busy rises the cycle after the start strobe and falls the cycle after the stop strobe or the timeout.
- Timeout frame_err asserts the cycle after the counter equals TIMEOUT_CYCLES.
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no strobe.
- Minimum PS/2 clock half-period supported: FILTER_LEN+3 clk cycles.

## Test plan
- Good frame for 0x1C (data LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1), 40 us half-period -> byte_valid once with byte_data=0x1C; key_valid with key_code=0x1C, key_ext=0, key_rel=0.
- Sequence E0, F0, 75 -> three byte_valid pulses; exactly one key_valid, with key_code=0x75, key_ext=1, key_rel=1. A following 0x1C gives key_ext=0, key_rel=0.
- Frame 0x1C with parity 1 -> parity_err pulse; no byte_valid; byte_data keeps its previous value. Frame 0x1C with stop bit 0 -> frame_err only.
- F0 followed by a bad-parity frame, then 0x29 -> key_valid with key_code=0x29, key_rel=0.
- Frame stops after 5 data bits, clock held high for TIMEOUT_CYCLES+10 -> frame_err pulse, busy returns to 0, and a following good 0x5A frame is received correctly.
- 3-cycle low glitches on ps2_clk while idle produce no busy and no strobe. rst_n pulsed low mid-frame, then a good 0x1C frame -> all outputs at reset values during reset, and 0x1C is received after release.
